// File: rtl/clock_pkg.sv
// Shared definitions for the clock/stopwatch mode controller: mode encoding,
// digit-field positions and the blink masks derived from them.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_HOUR  = 2'd1,
        MODE_SET_MIN   = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;

    // Digit positions inside the packed {h1,h2,m1,m2,s1,s2} word.
    localparam int FIELD_H1 = 5;
    localparam int FIELD_H2 = 4;
    localparam int FIELD_M1 = 3;
    localparam int FIELD_M2 = 2;

    localparam logic [NUM_DIGITS-1:0] BLANK_NONE = '0;
    localparam logic [NUM_DIGITS-1:0] BLANK_HOUR =
        (NUM_DIGITS'(1) << FIELD_H1) | (NUM_DIGITS'(1) << FIELD_H2);
    localparam logic [NUM_DIGITS-1:0] BLANK_MIN =
        (NUM_DIGITS'(1) << FIELD_M1) | (NUM_DIGITS'(1) << FIELD_M2);

    function automatic mode_t next_mode(input mode_t cur);
        logic [1:0] nxt;
        nxt = cur + 2'd1;
        return mode_t'(nxt);
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Front-panel / counter / display signal bundle of the mode controller.
// master = panel and counters side, slave = the controller itself.
interface clock_mode_ctrl_if;
    import clock_pkg::*;

    logic                            mode_btn;
    logic                            set_btn;
    logic                            start_btn;
    logic                            blink_tick;
    logic [NUM_DIGITS*DIGIT_W-1:0]   clk_digits;
    logic [NUM_DIGITS*DIGIT_W-1:0]   sw_digits;
    logic [NUM_DIGITS*DIGIT_W-1:0]   disp_digits;
    logic [NUM_DIGITS-1:0]           blank_mask;
    logic [1:0]                      mode;
    logic                            time_en;
    logic                            hour_inc;
    logic                            min_inc;
    logic                            sec_clr;
    logic                            sw_run;
    logic                            sw_clear;

    modport master (
        output mode_btn, set_btn, start_btn, blink_tick, clk_digits, sw_digits,
        input  disp_digits, blank_mask, mode, time_en, hour_inc, min_inc,
               sec_clr, sw_run, sw_clear
    );

    modport slave (
        input  mode_btn, set_btn, start_btn, blink_tick, clk_digits, sw_digits,
        output disp_digits, blank_mask, mode, time_en, hour_inc, min_inc,
               sec_clr, sw_run, sw_clear
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button plus a saturating hold counter
// on blink_tick that yields an auto-repeat request once the hold is long enough.
module btn_edge #(
    parameter int REPEAT_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    input  logic hold_clr,
    output logic edge_pulse,
    output logic repeat_pulse
);

    localparam int            CW       = $clog2(REPEAT_TICKS + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(REPEAT_TICKS);

    logic          prev_reg;
    logic [CW-1:0] hold_reg;
    logic [CW-1:0] hold_next;

    // prev resets high so a button held through reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
            hold_reg <= '0;
        end else begin
            prev_reg <= btn;
            hold_reg <= hold_next;
        end
    end

    always_comb begin
        hold_next = hold_reg;
        if (!btn || hold_clr) begin
            hold_next = '0;
        end else if (tick && (hold_reg != HOLD_MAX)) begin
            hold_next = hold_reg + CW'(1);
        end
    end

    assign edge_pulse   = btn & ~prev_reg;
    assign repeat_pulse = btn & tick & ~hold_clr & (hold_reg == HOLD_MAX);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock / stopwatch: button edges to control
// pulses, display source selection and blinking of the field being edited.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    clock_mode_ctrl_if.slave  bus
);

    localparam int         BTN_MODE     = 0;
    localparam int         BTN_SET      = 1;
    localparam int         BTN_START    = 2;
    localparam int         NUM_BTN      = 3;
    // Only the set button drives auto-repeat.
    localparam logic [NUM_BTN-1:0] REPEAT_USERS = NUM_BTN'(1) << BTN_SET;

    logic [NUM_BTN-1:0] btn_vec;
    logic [NUM_BTN-1:0] edge_vec;
    logic [NUM_BTN-1:0] rep_vec;
    logic               mode_edge;
    logic               set_edge;
    logic               start_edge;
    logic               set_rep;

    mode_t                          mode_reg,     mode_next;
    logic                           phase_reg,    phase_next;
    logic                           hour_inc_reg, hour_inc_next;
    logic                           min_inc_reg,  min_inc_next;
    logic                           sec_clr_reg,  sec_clr_next;
    logic                           sw_clear_reg, sw_clear_next;
    logic                           sw_run_reg,   sw_run_next;
    logic [NUM_DIGITS-1:0]          blank_reg,    blank_next;
    logic [NUM_DIGITS*DIGIT_W-1:0]  disp_reg,     disp_next;

    assign btn_vec = {bus.start_btn, bus.set_btn, bus.mode_btn};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge #(
                .REPEAT_TICKS (REPEAT_TICKS)
            ) u_btn_edge (
                .clk          (clk),
                .reset        (reset),
                .btn          (btn_vec[gi]),
                .tick         (bus.blink_tick),
                .hold_clr     (mode_edge),
                .edge_pulse   (edge_vec[gi]),
                .repeat_pulse (rep_vec[gi])
            );
        end
    endgenerate

    assign mode_edge  = edge_vec[BTN_MODE];
    assign set_edge   = edge_vec[BTN_SET];
    assign start_edge = edge_vec[BTN_START];
    assign set_rep    = |(rep_vec & REPEAT_USERS);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg     <= MODE_CLOCK;
            phase_reg    <= 1'b0;
            hour_inc_reg <= 1'b0;
            min_inc_reg  <= 1'b0;
            sec_clr_reg  <= 1'b0;
            sw_clear_reg <= 1'b0;
            sw_run_reg   <= 1'b0;
            blank_reg    <= BLANK_NONE;
            disp_reg     <= '0;
        end else begin
            mode_reg     <= mode_next;
            phase_reg    <= phase_next;
            hour_inc_reg <= hour_inc_next;
            min_inc_reg  <= min_inc_next;
            sec_clr_reg  <= sec_clr_next;
            sw_clear_reg <= sw_clear_next;
            sw_run_reg   <= sw_run_next;
            blank_reg    <= blank_next;
            disp_reg     <= disp_next;
        end
    end

    // A mode press wins over a same-cycle set press; the set edge is dropped.
    always_comb begin
        mode_next     = mode_reg;
        phase_next    = phase_reg;
        hour_inc_next = 1'b0;
        min_inc_next  = 1'b0;
        sec_clr_next  = 1'b0;
        sw_clear_next = 1'b0;
        sw_run_next   = sw_run_reg;

        if (mode_edge) begin
            mode_next  = next_mode(mode_reg);
            phase_next = 1'b0;
            if (mode_reg == MODE_SET_MIN) begin
                sec_clr_next = 1'b1;
            end
        end else begin
            case (mode_reg)
                MODE_SET_HOUR: begin
                    hour_inc_next = set_edge | set_rep;
                    if (bus.blink_tick) phase_next = ~phase_reg;
                end
                MODE_SET_MIN: begin
                    min_inc_next = set_edge | set_rep;
                    if (bus.blink_tick) phase_next = ~phase_reg;
                end
                MODE_STOPWATCH: begin
                    sw_clear_next = set_edge & ~sw_run_reg;
                end
                default: ;
            endcase
        end

        // Clear above looks at the pre-toggle run state.
        if ((mode_reg == MODE_STOPWATCH) && start_edge) begin
            sw_run_next = ~sw_run_reg;
        end
    end

    always_comb begin
        blank_next = BLANK_NONE;
        case (mode_reg)
            MODE_SET_HOUR: blank_next = phase_reg ? BLANK_HOUR : BLANK_NONE;
            MODE_SET_MIN:  blank_next = phase_reg ? BLANK_MIN  : BLANK_NONE;
            default:       blank_next = BLANK_NONE;
        endcase
        disp_next = (mode_reg == MODE_STOPWATCH) ? bus.sw_digits : bus.clk_digits;
    end

    assign bus.mode        = mode_reg;
    assign bus.time_en     = (mode_reg == MODE_CLOCK) || (mode_reg == MODE_STOPWATCH);
    assign bus.hour_inc    = hour_inc_reg;
    assign bus.min_inc     = min_inc_reg;
    assign bus.sec_clr     = sec_clr_reg;
    assign bus.sw_run      = sw_run_reg;
    assign bus.sw_clear    = sw_clear_reg;
    assign bus.blank_mask  = blank_reg;
    assign bus.disp_digits = disp_reg;

endmodule
